// File: rtl/md_unit_pkg.sv
// Shared multiply/divide definitions: MDOp encodings and default latencies
// used by md_unit, the controller and the hazard unit.
package md_unit_pkg;

  typedef enum logic [3:0] {
    MD_NOP   = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MFHI  = 4'd7,
    MD_MFLO  = 4'd8,
    MD_MADD  = 4'd9,
    MD_MADDU = 4'd10,
    MD_MSUB  = 4'd11,
    MD_MSUBU = 4'd12
  } md_op_e;

  localparam int MD_MULT_CYCLES = 5;
  localparam int MD_DIV_CYCLES  = 10;
  localparam int MD_CNT_W       = 16;

endpackage

// File: rtl/md_unit.sv
// HI/LO multiply-divide unit with fixed-latency busy period and inline 64-bit compute.
// Optional multiply-accumulate ops (MADD/MADDU/MSUB/MSUBU) enabled by defining MD_MADD_EN.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [3:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        IntReq,
  output logic        Busy,
  output logic [31:0] MD_out
);

  logic [31:0]         hi_q, hi_d;
  logic [31:0]         lo_q, lo_d;
  logic [31:0]         a_q, a_d;
  logic [31:0]         b_q, b_d;
  logic [3:0]          op_q, op_d;
  logic [MD_CNT_W-1:0] cnt_q, cnt_d;

  logic        busy;
  logic        accept;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        div_signed;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic [31:0] uquot;
  logic [31:0] urem;
  logic [31:0] quot;
  logic [31:0] rem;

  assign busy   = (cnt_q != '0);
  assign Busy   = busy;
  assign accept = Start && !IntReq && !busy;

  // Operands are sign/zero extended to 64 bits so the low 64 bits of the product are exact.
  assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
  assign prod_u = {32'b0, a_q} * {32'b0, b_q};

  // Signed divide runs on magnitudes, then fixes signs: quotient truncates toward zero,
  // remainder follows the dividend. 0x80000000 / -1 wraps back to 0x80000000.
  assign div_signed = (op_q == MD_DIV);
  assign a_neg      = div_signed && a_q[31];
  assign b_neg      = div_signed && b_q[31];
  assign div_a      = a_neg ? (~a_q + 32'd1) : a_q;
  assign div_b      = b_neg ? (~b_q + 32'd1) : b_q;
  assign uquot      = (div_b != '0) ? (div_a / div_b) : '0;
  assign urem       = (div_b != '0) ? (div_a % div_b) : '0;
  assign quot       = (a_neg ^ b_neg) ? (~uquot + 32'd1) : uquot;
  assign rem        = a_neg ? (~urem + 32'd1) : urem;

  always_comb begin
    hi_d  = hi_q;
    lo_d  = lo_q;
    a_d   = a_q;
    b_d   = b_q;
    op_d  = op_q;
    cnt_d = cnt_q;
    if (busy) begin
      cnt_d = cnt_q - MD_CNT_W'(1);
      if (cnt_q == MD_CNT_W'(1)) begin
        case (op_q)
          MD_MULT:  {hi_d, lo_d} = prod_s;
          MD_MULTU: {hi_d, lo_d} = prod_u;
          MD_DIV, MD_DIVU: begin
            if (b_q != '0) begin
              hi_d = rem;
              lo_d = quot;
            end
          end
`ifdef MD_MADD_EN
          MD_MADD:  {hi_d, lo_d} = {hi_q, lo_q} + prod_s;
          MD_MADDU: {hi_d, lo_d} = {hi_q, lo_q} + prod_u;
          MD_MSUB:  {hi_d, lo_d} = {hi_q, lo_q} - prod_s;
          MD_MSUBU: {hi_d, lo_d} = {hi_q, lo_q} - prod_u;
`endif
          default: ;
        endcase
      end
    end else if (accept) begin
      case (MDOp)
        MD_MULT, MD_MULTU
`ifdef MD_MADD_EN
        , MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU
`endif
        : begin
          a_d   = A;
          b_d   = B;
          op_d  = MDOp;
          cnt_d = MD_CNT_W'(MULT_CYCLES);
        end
        MD_DIV, MD_DIVU: begin
          a_d   = A;
          b_d   = B;
          op_d  = MDOp;
          cnt_d = MD_CNT_W'(DIV_CYCLES);
        end
        MD_MTHI: hi_d = A;
        MD_MTLO: lo_d = A;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q  <= '0;
      lo_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      cnt_q <= '0;
    end else begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      a_q   <= a_d;
      b_q   <= b_d;
      op_q  <= op_d;
      cnt_q <= cnt_d;
    end
  end

  // mf* reads are unqualified; the hazard unit keeps them from issuing while busy.
  always_comb begin
    MD_out = '0;
    case (MDOp)
      MD_MFHI: MD_out = hi_q;
      MD_MFLO: MD_out = lo_q;
      default: ;
    endcase
  end

endmodule
